sgf_round_ctrl: RTL

SGF_ROUND_CTRL -- requirements
Module: sgf_round_ctrl

---
 rtl/sgf_round_ctrl_pkg.sv | 33 +++
 rtl/sgf_incr.sv | 20 ++
 rtl/sgf_round_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sgf_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sgf_round_ctrl_pkg
// Description : Shared round-type constants, FSM state encoding and the
//               directed-rounding decision helper for sgf_round_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package sgf_round_ctrl_pkg;

  // Round_Type_i encodings; 2'b11 is reserved and never rounds.
  localparam logic [1:0] RT_ZERO = 2'b00;
  localparam logic [1:0] RT_NEG  = 2'b01;
  localparam logic [1:0] RT_POS  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECIDE = 3'd1,
    ST_ADD    = 3'd2,
    ST_NORM   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Directed rounding moves the magnitude up only when the discarded bits
  // are non-zero and the rounding direction points away from zero.
  function automatic logic round_up_decision(input logic [1:0] rt,
                                             input logic       sign,
                                             input logic [1:0] guard_sticky);
    return (guard_sticky != 2'b00) &&
           (((rt == RT_NEG) && sign) || ((rt == RT_POS) && !sign));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sgf_incr.sv
`default_nettype none
// ============================================================================
// Module      : sgf_incr
// Description : W-bit incrementer with carry-out used by the rounding step.
// Revision    : 1.0 - initial release
// ============================================================================
module sgf_incr #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic         inc,
  output logic [W-1:0] sum,
  output logic         carry
);
  import sgf_round_ctrl_pkg::*;

  assign {carry, sum} = {1'b0, a} + {{W{1'b0}}, inc};

endmodule
`default_nettype wire

// File: rtl/sgf_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sgf_round_ctrl
// Description : Multi-cycle directed-rounding controller for a floating-point
//               significand: decide, increment, renormalise, then hold the
//               result under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sgf_round_ctrl #(
  parameter int SW = 23,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [SW:0]   Sgf_i,
  input  logic [EW-1:0] Exp_i,
  input  logic [1:0]    Data_i,
  input  logic [1:0]    Round_Type_i,
  input  logic          Sign_Result_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [SW-1:0] Sgf_o,
  output logic [EW-1:0] Exp_o,
  output logic          Sign_o,
  output logic          Overflow_o
);
  import sgf_round_ctrl_pkg::*;

  state_t        state;
  state_t        next_state;

  // Operand captured on accept; stays constant for the whole transaction.
  logic [SW:0]   op_sgf;
  logic [EW-1:0] op_exp;
  logic [1:0]    op_gs;
  logic [1:0]    op_rt;
  logic          op_sign;

  logic          round_up;
  logic [SW:0]   sum;
  logic          carry;

  logic [SW:0]   incr_sum;
  logic          incr_carry;
  logic [EW-1:0] exp_inc;

  assign exp_inc = op_exp + EW'(1);

  sgf_incr #(.W(SW + 1)) u_incr (
    .a     (op_sgf),
    .inc   (round_up),
    .sum   (incr_sum),
    .carry (incr_carry)
  );

  // State register; reset always returns to IDLE and abandons any operand.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state sequencing and handshake outputs, one step per cycle.
  always_comb begin
    next_state  = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) next_state = ST_DECIDE;
      end
      ST_DECIDE: next_state = ST_ADD;
      ST_ADD:    next_state = ST_NORM;
      ST_NORM:   next_state = ST_DONE;
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) next_state = ST_IDLE;
      end
      default:   next_state = ST_IDLE;
    endcase
  end

  // Datapath: capture, decide, increment, then renormalise into the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_sgf     <= '0;
      op_exp     <= '0;
      op_gs      <= '0;
      op_rt      <= '0;
      op_sign    <= 1'b0;
      round_up   <= 1'b0;
      sum        <= '0;
      carry      <= 1'b0;
      Sgf_o      <= '0;
      Exp_o      <= '0;
      Sign_o     <= 1'b0;
      Overflow_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            op_sgf  <= Sgf_i;
            op_exp  <= Exp_i;
            op_gs   <= Data_i;
            op_rt   <= Round_Type_i;
            op_sign <= Sign_Result_i;
          end
        end
        ST_DECIDE: begin
          // Inf/NaN operands (exponent all-ones) pass through untouched.
          round_up <= (&op_exp) ? 1'b0
                                : round_up_decision(op_rt, op_sign, op_gs);
        end
        ST_ADD: begin
          carry <= incr_carry;
          sum   <= incr_sum;
        end
        ST_NORM: begin
          Sign_o <= op_sign;
          if (carry) begin
            // The increment rippled past the hidden bit: renormalise.
            if (&exp_inc) begin
              Sgf_o      <= '0;
              Exp_o      <= '1;
              Overflow_o <= 1'b1;
            end else begin
              Sgf_o      <= sum[SW:1];
              Exp_o      <= exp_inc;
              Overflow_o <= 1'b0;
            end
          end else begin
            Sgf_o      <= sum[SW-1:0];
            Exp_o      <= op_exp;
            Overflow_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
